// File: rtl/control_unit_multicycle_if.sv
// Memory handshake bundle between the multi-cycle control unit and the
// instruction/data memories. The control unit is the master: it raises the
// requests and the memories answer with the ready signals.
interface control_unit_multicycle_if;
    logic i_mem_req;
    logic i_mem_ready;
    logic memRead;
    logic memWrite;
    logic d_mem_ready;

    modport master (
        output i_mem_req,
        output memRead,
        output memWrite,
        input  i_mem_ready,
        input  d_mem_ready
    );

    modport slave (
        input  i_mem_req,
        input  memRead,
        input  memWrite,
        output i_mem_ready,
        output d_mem_ready
    );
endinterface

// File: rtl/control_unit_multicycle.sv
// Multi-cycle control unit for the BRISC-V core.
// Steps each RV32I instruction through FETCH, DECODE, EXECUTE, MEM and
// WRITEBACK, latches the decode fields once per instruction and emits
// one-cycle datapath strobes. A memory wait longer than MEM_TIMEOUT cycles or
// an unknown opcode parks the FSM in TRAP until reset.
// Optional feature: define CONTROL_UNIT_PERF_CNT_EN to build the cycle and
// retired-instruction counters; otherwise both outputs are tied to zero.
module control_unit_multicycle #(
    parameter int CORE        = 0,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    control_unit_multicycle_if.master     mem_if,
    input  logic [6:0]                    opcode,
    input  logic                          hold,
    output logic                          ir_write,
    output logic                          regWrite,
    output logic                          pc_write,
    output logic                          branch_op,
    output logic                          memtoReg,
    output logic                          operand_B_sel,
    output logic [2:0]                    ALUOp,
    output logic [1:0]                    next_PC_sel,
    output logic [1:0]                    operand_A_sel,
    output logic [1:0]                    extend_sel,
    output logic                          illegal_instr,
    output logic                          timeout,
    output logic [2:0]                    state,
    output logic [CNT_WIDTH-1:0]          cycle_count,
    output logic [CNT_WIDTH-1:0]          instr_retired
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_ILLEGAL = 4'd0,
        CL_R       = 4'd1,
        CL_I       = 4'd2,
        CL_STORE   = 4'd3,
        CL_LOAD    = 4'd4,
        CL_BRANCH  = 4'd5,
        CL_JALR    = 4'd6,
        CL_JAL     = 4'd7,
        CL_AUIPC   = 4'd8,
        CL_LUI     = 4'd9,
        CL_FENCE   = 4'd10,
        CL_SYSTEM  = 4'd11
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic       branch_op;
        logic       mem_to_reg;
        logic       op_b_sel;
        logic [2:0] alu_op;
        logic [1:0] next_pc_sel;
        logic [1:0] op_a_sel;
        logic [1:0] ext_sel;
    } dec_t;

    // Wait counter only needs to reach MEM_TIMEOUT-1; at least one bit wide.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int LIMIT  = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;

    state_t            state_r;
    state_t            state_next_s;
    dec_t              dec_r;
    dec_t              dec_s;
    logic              illegal_r;
    logic              timeout_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    logic hold_eff_s;
    logic ready_s;
    logic wait_expire_s;
    logic req_s;
    logic ir_s;
    logic rd_s;
    logic wr_s;
    logic reg_s;
    logic pc_s;
    logic set_illegal_s;
    logic set_timeout_s;

    assign hold_eff_s    = hold && (state_r != ST_TRAP);
    assign ready_s       = (state_r == ST_FETCH) ? mem_if.i_mem_ready : mem_if.d_mem_ready;
    assign wait_expire_s = (MEM_TIMEOUT != 0) && (wait_cnt_r == WAIT_W'(LIMIT));

    // Opcode decode into an instruction class plus the datapath control fields.
    always_comb begin
        dec_s = '0;
        case (opcode)
            7'b0110011: dec_s.cls = CL_R;
            7'b0010011: dec_s.cls = CL_I;
            7'b0100011: dec_s.cls = CL_STORE;
            7'b0000011: dec_s.cls = CL_LOAD;
            7'b1100011: dec_s.cls = CL_BRANCH;
            7'b1100111: dec_s.cls = CL_JALR;
            7'b1101111: dec_s.cls = CL_JAL;
            7'b0010111: dec_s.cls = CL_AUIPC;
            7'b0110111: dec_s.cls = CL_LUI;
            7'b0001111: dec_s.cls = CL_FENCE;
            7'b1110011: dec_s.cls = CL_SYSTEM;
            default:    dec_s.cls = CL_ILLEGAL;
        endcase
        case (dec_s.cls)
            CL_I: begin
                dec_s.alu_op   = 3'b001;
                dec_s.op_b_sel = 1'b1;
            end
            CL_STORE: begin
                dec_s.alu_op   = 3'b101;
                dec_s.op_b_sel = 1'b1;
                dec_s.ext_sel  = 2'b01;
            end
            CL_LOAD: begin
                dec_s.alu_op     = 3'b100;
                dec_s.op_b_sel   = 1'b1;
                dec_s.mem_to_reg = 1'b1;
            end
            CL_BRANCH: begin
                dec_s.alu_op      = 3'b010;
                dec_s.next_pc_sel = 2'b01;
                dec_s.branch_op   = 1'b1;
            end
            CL_JAL: begin
                dec_s.alu_op      = 3'b011;
                dec_s.op_a_sel    = 2'b10;
                dec_s.next_pc_sel = 2'b10;
            end
            CL_JALR: begin
                dec_s.alu_op      = 3'b011;
                dec_s.op_a_sel    = 2'b10;
                dec_s.next_pc_sel = 2'b11;
            end
            CL_AUIPC: begin
                dec_s.alu_op   = 3'b110;
                dec_s.op_a_sel = 2'b01;
                dec_s.op_b_sel = 1'b1;
                dec_s.ext_sel  = 2'b10;
            end
            CL_LUI: begin
                dec_s.alu_op   = 3'b110;
                dec_s.op_a_sel = 2'b11;
                dec_s.op_b_sel = 1'b1;
                dec_s.ext_sel  = 2'b10;
            end
            default: dec_s.alu_op = 3'b000;
        endcase
    end

    // Next-state and strobe generation; hold freezes the FSM and masks strobes.
    always_comb begin
        state_next_s  = state_r;
        req_s         = 1'b0;
        ir_s          = 1'b0;
        rd_s          = 1'b0;
        wr_s          = 1'b0;
        reg_s         = 1'b0;
        pc_s          = 1'b0;
        set_illegal_s = 1'b0;
        set_timeout_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                req_s = 1'b1;
                if (mem_if.i_mem_ready) begin
                    ir_s         = 1'b1;
                    state_next_s = ST_DECODE;
                end else if (wait_expire_s) begin
                    set_timeout_s = 1'b1;
                    state_next_s  = ST_TRAP;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_s.cls == CL_ILLEGAL) begin
                    set_illegal_s = 1'b1;
                    state_next_s  = ST_TRAP;
                end else begin
                    state_next_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (dec_r.cls)
                    CL_LOAD, CL_STORE: state_next_s = ST_MEM;
                    CL_BRANCH, CL_FENCE, CL_SYSTEM: begin
                        pc_s         = 1'b1;
                        state_next_s = ST_FETCH;
                    end
                    default: state_next_s = ST_WRITEBACK;
                endcase
            end
            ST_MEM: begin
                if (dec_r.cls == CL_LOAD) begin
                    rd_s = 1'b1;
                end else begin
                    wr_s = 1'b1;
                end
                if (mem_if.d_mem_ready) begin
                    if (dec_r.cls == CL_LOAD) begin
                        state_next_s = ST_WRITEBACK;
                    end else begin
                        pc_s         = 1'b1;
                        state_next_s = ST_FETCH;
                    end
                end else if (wait_expire_s) begin
                    set_timeout_s = 1'b1;
                    state_next_s  = ST_TRAP;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WRITEBACK: begin
                reg_s        = 1'b1;
                pc_s         = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_TRAP: state_next_s = ST_TRAP;
            default: begin
                set_timeout_s = 1'b1;
                state_next_s  = ST_TRAP;
            end
        endcase
        if (hold_eff_s) begin
            state_next_s  = state_r;
            ir_s          = 1'b0;
            reg_s         = 1'b0;
            pc_s          = 1'b0;
            set_illegal_s = 1'b0;
            set_timeout_s = 1'b0;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Decode fields latched once per instruction, in DECODE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dec_r <= '0;
        end else if ((state_r == ST_DECODE) && !hold_eff_s) begin
            dec_r <= dec_s;
        end else begin
            dec_r <= dec_r;
        end
    end

    // Sticky trap-cause flags; only reset clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            illegal_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r | set_illegal_s;
            timeout_r <= timeout_r | set_timeout_s;
        end
    end

    // Memory wait counter: cleared on every state change, counts non-ready cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= '0;
        end else if (hold_eff_s) begin
            wait_cnt_r <= wait_cnt_r;
        end else if (state_next_s != state_r) begin
            wait_cnt_r <= '0;
        end else if (((state_r == ST_FETCH) || (state_r == ST_MEM)) && !ready_s) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Strobes and requests are forced low for as long as reset is asserted.
    assign mem_if.i_mem_req = req_s & reset;
    assign mem_if.memRead   = rd_s  & reset;
    assign mem_if.memWrite  = wr_s  & reset;
    assign ir_write         = ir_s  & reset;
    assign regWrite         = reg_s & reset;
    assign pc_write         = pc_s  & reset;

    assign branch_op     = dec_r.branch_op;
    assign memtoReg      = dec_r.mem_to_reg;
    assign operand_B_sel = dec_r.op_b_sel;
    assign ALUOp         = dec_r.alu_op;
    assign next_PC_sel   = dec_r.next_pc_sel;
    assign operand_A_sel = dec_r.op_a_sel;
    assign extend_sel    = dec_r.ext_sel;
    assign illegal_instr = illegal_r;
    assign timeout       = timeout_r;
    assign state         = state_r;

`ifdef CONTROL_UNIT_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cycle_cnt_r;
    logic [CNT_WIDTH-1:0] retired_cnt_r;

    // Performance counters: cycles outside TRAP and completed instructions.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt_r   <= '0;
            retired_cnt_r <= '0;
        end else begin
            if (state_r != ST_TRAP) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_WIDTH'(1);
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
            if (pc_s) begin
                retired_cnt_r <= retired_cnt_r + CNT_WIDTH'(1);
            end else begin
                retired_cnt_r <= retired_cnt_r;
            end
        end
    end

    assign cycle_count   = cycle_cnt_r;
    assign instr_retired = retired_cnt_r;
`else
    assign cycle_count   = {CNT_WIDTH{1'b0}};
    assign instr_retired = {CNT_WIDTH{1'b0}};
`endif

endmodule
